// File: rtl/hack_pkg.sv
// Shared types and widths for the Hack ROM loader: FSM state encoding,
// ROM address/word widths and the running-checksum update helper.
package hack_pkg;

  localparam int HACK_ADDR_W = 15;
  localparam int HACK_WORD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_WRITE   = 3'd5,
    ST_CHECK   = 3'd6,
    ST_ERROR   = 3'd7
  } hack_state_t;

  // Running XOR over every data byte of the program image.
  function automatic logic [7:0] hack_csum_next(input logic [7:0] csum,
                                                input logic [7:0] data_byte);
    return csum ^ data_byte;
  endfunction

endpackage

// File: rtl/hack_byte_assembler.sv
// Builds a 16-bit instruction word from two bytes, high byte first, and
// raises a one-cycle valid pulse on the cycle after the low byte lands.
module hack_byte_assembler
  import hack_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   hi_en,
  input  logic                   lo_en,
  input  logic [7:0]             byte_in,
  output logic [HACK_WORD_W-1:0] word,
  output logic                   word_valid
);

  logic [HACK_WORD_W-1:0] word_r;
  logic                   valid_r;

  // Byte capture into the word register and valid pulse generation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_r  <= 16'h0000;
      valid_r <= 1'b0;
    end else begin
      valid_r <= lo_en;
      if (hi_en) begin
        word_r[15:8] <= byte_in;
      end else if (lo_en) begin
        word_r[7:0] <= byte_in;
      end
    end
  end

  assign word       = word_r;
  assign word_valid = valid_r;

endmodule

// File: rtl/hack_rom_loader.sv
// Serial program downloader for the Hack CPU instruction ROM: length header,
// big-endian words, optional XOR checksum (macro HACK_LOADER_CHECKSUM_EN).
module hack_rom_loader
  import hack_pkg::*;
#(
  parameter int MAX_WORDS = 32768
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load_req,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic                   rom_we,
  output logic [HACK_ADDR_W-1:0] rom_addr,
  output logic [HACK_WORD_W-1:0] rom_wdata,
  output logic                   cpu_reset,
  output logic                   cpu_hlt,
  output logic                   done,
  output logic                   error
);

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  hack_state_t            state_r;
  hack_state_t            state_nx_s;
  logic [15:0]            len_r;
  logic [HACK_ADDR_W-1:0] addr_r;
  logic                   rx_ready_r;
  logic                   cpu_reset_r;
  logic                   cpu_hlt_r;
  logic                   done_r;
  logic                   error_r;
  logic                   done_nx_s;
  logic                   rx_ready_nx_s;
  logic                   hold_nx_s;
  logic                   error_nx_s;
  logic                   xfer_s;
  logic [15:0]            len_full_s;
  logic                   last_word_s;
`ifdef HACK_LOADER_CHECKSUM_EN
  logic [7:0]             csum_r;
`endif

  assign xfer_s      = rx_valid & rx_ready_r;
  assign len_full_s  = {len_r[15:8], rx_data};
  // 16-bit compare so a full 32768-word image terminates without a wrap write.
  assign last_word_s = (({1'b0, addr_r} + 16'd1) == len_r);

  // Next-state and next-output decode.
  always_comb begin
    state_nx_s = state_r;
    done_nx_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (load_req) state_nx_s = ST_LEN_HI;
        else          state_nx_s = ST_IDLE;
      end
      ST_LEN_HI: begin
        if (xfer_s) state_nx_s = ST_LEN_LO;
        else        state_nx_s = ST_LEN_HI;
      end
      ST_LEN_LO: begin
        if (!xfer_s) begin
          state_nx_s = ST_LEN_LO;
        end else if (len_full_s > MAX_N) begin
          state_nx_s = ST_ERROR;
        end else if (len_full_s == 16'd0) begin
`ifdef HACK_LOADER_CHECKSUM_EN
          state_nx_s = ST_CHECK;
`else
          state_nx_s = ST_IDLE;
          done_nx_s  = 1'b1;
`endif
        end else begin
          state_nx_s = ST_DATA_HI;
        end
      end
      ST_DATA_HI: begin
        if (xfer_s) state_nx_s = ST_DATA_LO;
        else        state_nx_s = ST_DATA_HI;
      end
      ST_DATA_LO: begin
        if (xfer_s) state_nx_s = ST_WRITE;
        else        state_nx_s = ST_DATA_LO;
      end
      ST_WRITE: begin
        if (last_word_s) begin
`ifdef HACK_LOADER_CHECKSUM_EN
          state_nx_s = ST_CHECK;
`else
          state_nx_s = ST_IDLE;
          done_nx_s  = 1'b1;
`endif
        end else begin
          state_nx_s = ST_DATA_HI;
        end
      end
      ST_CHECK: begin
`ifdef HACK_LOADER_CHECKSUM_EN
        if (!xfer_s) begin
          state_nx_s = ST_CHECK;
        end else if (rx_data == csum_r) begin
          state_nx_s = ST_IDLE;
          done_nx_s  = 1'b1;
        end else begin
          state_nx_s = ST_ERROR;
        end
`else
        state_nx_s = ST_IDLE;
`endif
      end
      ST_ERROR: begin
        if (load_req) state_nx_s = ST_LEN_HI;
        else          state_nx_s = ST_ERROR;
      end
      default: state_nx_s = ST_IDLE;
    endcase

    rx_ready_nx_s = (state_nx_s == ST_LEN_HI)  || (state_nx_s == ST_LEN_LO) ||
                    (state_nx_s == ST_DATA_HI) || (state_nx_s == ST_DATA_LO) ||
                    (state_nx_s == ST_CHECK);
    hold_nx_s     = (state_nx_s != ST_IDLE);
    error_nx_s    = (state_nx_s == ST_ERROR);
  end

  // Loader FSM: state, registered control outputs, length, address and checksum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      len_r       <= 16'h0000;
      addr_r      <= 15'h0000;
      rx_ready_r  <= 1'b0;
      cpu_reset_r <= 1'b0;
      cpu_hlt_r   <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
`ifdef HACK_LOADER_CHECKSUM_EN
      csum_r      <= 8'h00;
`endif
    end else begin
      state_r     <= state_nx_s;
      rx_ready_r  <= rx_ready_nx_s;
      cpu_reset_r <= hold_nx_s;
      cpu_hlt_r   <= hold_nx_s;
      done_r      <= done_nx_s;
      error_r     <= error_nx_s;
      if ((state_r == ST_LEN_HI) && xfer_s) begin
        len_r[15:8] <= rx_data;
      end
      if ((state_r == ST_LEN_LO) && xfer_s) begin
        len_r[7:0] <= rx_data;
        addr_r     <= 15'h0000;
      end else if ((state_r == ST_WRITE) && !last_word_s) begin
        addr_r <= addr_r + 15'd1;
      end
`ifdef HACK_LOADER_CHECKSUM_EN
      if ((state_nx_s == ST_LEN_HI) && (state_r != ST_LEN_HI)) begin
        csum_r <= 8'h00;
      end else if (xfer_s && ((state_r == ST_DATA_HI) || (state_r == ST_DATA_LO))) begin
        csum_r <= hack_csum_next(csum_r, rx_data);
      end
`endif
    end
  end

  hack_byte_assembler u_asm (
    .clk        (clk),
    .reset_n    (reset_n),
    .hi_en      ((state_r == ST_DATA_HI) && xfer_s),
    .lo_en      ((state_r == ST_DATA_LO) && xfer_s),
    .byte_in    (rx_data),
    .word       (rom_wdata),
    .word_valid (rom_we)
  );

  assign rx_ready  = rx_ready_r;
  assign rom_addr  = addr_r;
  assign cpu_reset = cpu_reset_r;
  assign cpu_hlt   = cpu_hlt_r;
  assign done      = done_r;
  assign error     = error_r;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Directed self-checking bench for hack_rom_loader (MAX_WORDS=4); follows
// HACK_LOADER_CHECKSUM_EN to append checksum bytes where the design expects them.
module tb_hack_rom_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_req;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rom_we;
  logic [14:0] rom_addr;
  logic [15:0] rom_wdata;
  logic        cpu_reset;
  logic        cpu_hlt;
  logic        done;
  logic        error;

`ifdef HACK_LOADER_CHECKSUM_EN
  localparam int LAT_END = 0;
`else
  localparam int LAT_END = 1;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int xfer_cyc = 0;
  int done_cyc = 0;
  int base;
  int dbase;
  logic [14:0] wr_addr [16];
  logic [15:0] wr_data [16];

  hack_rom_loader #(.MAX_WORDS(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_req  (load_req),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .cpu_reset (cpu_reset),
    .cpu_hlt   (cpu_hlt),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rom_we) begin
      if (wr_cnt < 16) begin
        wr_addr[wr_cnt] = rom_addr;
        wr_data[wr_cnt] = rom_wdata;
      end
      wr_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bit got;
    got = 1'b0;
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      if (rx_ready) begin
        got = 1'b1;
        xfer_cyc = cyc + 1;
      end
      tick();
    end
    rx_valid = 1'b0;
    if (!got) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (done) begin
        found = 1'b1;
        done_cyc = cyc;
      end else begin
        tick();
      end
    end
    chk({tag, "_done_seen"}, {31'd0, found}, 32'd1);
    if (found) begin
      chk({tag, "_done_latency"}, done_cyc - xfer_cyc, exp_lat);
      chk({tag, "_cpu_released"}, {30'd0, cpu_reset, cpu_hlt}, 32'd0);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    load_req = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #1;
    chk("reset_ctrl", {26'd0, rx_ready, rom_we, cpu_reset, cpu_hlt, done, error}, 32'd0);
    chk("reset_addr", rom_addr, 32'd0);
    chk("reset_wdata", rom_wdata, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Two-word image
    base = wr_cnt; dbase = done_cnt;
    do_load();
    chk("load_hold", {29'd0, cpu_reset, cpu_hlt, rx_ready}, 32'd7);
    send(8'h00, 0); send(8'h02, 0);
    send(8'h12, 0); send(8'h34, 0); send(8'hAB, 0); send(8'hCD, 0);
`ifdef HACK_LOADER_CHECKSUM_EN
    send(8'h40, 0);
`endif
    wait_done("basic", LAT_END);
    tick();
    chk("basic_wr_count", wr_cnt - base, 32'd2);
    chk("basic_addr0", wr_addr[base], 32'h0000);
    chk("basic_data0", wr_data[base], 32'h1234);
    chk("basic_addr1", wr_addr[base + 1], 32'h0001);
    chk("basic_data1", wr_data[base + 1], 32'hABCD);
    chk("basic_done_count", done_cnt - dbase, 32'd1);

    // Zero-length image
    base = wr_cnt; dbase = done_cnt;
    do_load();
    send(8'h00, 0); send(8'h00, 0);
`ifdef HACK_LOADER_CHECKSUM_EN
    send(8'h00, 0);
`endif
    wait_done("zero", 0);
    tick();
    chk("zero_wr_count", wr_cnt - base, 32'd0);
    chk("zero_done_count", done_cnt - dbase, 32'd1);

    // Oversize length, then recovery
    base = wr_cnt;
    do_load();
    send(8'h00, 0); send(8'h05, 0);
    tick();
    chk("over_flags", {28'd0, error, cpu_hlt, cpu_reset, rx_ready}, 32'hE);
    chk("over_no_write", wr_cnt - base, 32'd0);
    do_load();
    chk("recover_err_clear", {31'd0, error}, 32'd0);
    send(8'h00, 0); send(8'h01, 0); send(8'h55, 0); send(8'hAA, 0);
`ifdef HACK_LOADER_CHECKSUM_EN
    send(8'hFF, 0);
`endif
    wait_done("recover", LAT_END);
    tick();
    chk("recover_wr_count", wr_cnt - base, 32'd1);
    chk("recover_data", wr_data[base], 32'h55AA);

    // N == MAX_WORDS with random rx_valid gaps
    base = wr_cnt;
    do_load();
    send(8'h00, $urandom_range(0, 4)); send(8'h04, $urandom_range(0, 4));
    for (int i = 0; i < 8; i++) send(8'(i), $urandom_range(0, 4));
`ifdef HACK_LOADER_CHECKSUM_EN
    send(8'h00, $urandom_range(0, 4));
`endif
    wait_done("max_gap", LAT_END);
    tick();
    chk("max_wr_count", wr_cnt - base, 32'd4);
    for (int j = 0; j < 4; j++) begin
      chk("max_addr", wr_addr[base + j], j);
      chk("max_data", wr_data[base + j], (2 * j) * 256 + 2 * j + 1);
    end

`ifdef HACK_LOADER_CHECKSUM_EN
    // Checksum mismatch then match
    do_load();
    send(8'h00, 0); send(8'h01, 0); send(8'hFF, 0); send(8'h00, 0); send(8'h00, 0);
    tick();
    chk("csum_bad_error", {31'd0, error}, 32'd1);
    do_load();
    send(8'h00, 0); send(8'h01, 0); send(8'hFF, 0); send(8'h00, 0); send(8'hFF, 0);
    wait_done("csum_good", 0);
    chk("csum_good_error", {31'd0, error}, 32'd0);
`endif

    // Reset mid-download
    do_load();
    send(8'h00, 0); send(8'h02, 0); send(8'h12, 0);
    chk("abort_pre_hold", {30'd0, cpu_reset, cpu_hlt}, 32'd3);
    base = wr_cnt;
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_ctrl", {26'd0, rx_ready, rom_we, cpu_reset, cpu_hlt, done, error}, 32'd0);
    chk("abort_addr", rom_addr, 32'd0);
    chk("abort_wdata", rom_wdata, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    chk("abort_no_write", wr_cnt - base, 32'd0);
    chk("abort_idle", {29'd0, cpu_reset, cpu_hlt, rx_ready}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hack_rom_loader.md
HACK_ROM_LOADER -- requirements
Module: hack_rom_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 32768, maximum number of 16-bit instruction words accepted (1..32768).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port load_req  input  1  level; sampled in IDLE to begin a program download.
REQ-005 SHALL have port rx_data  input  8  byte from the upstream serial receiver.
REQ-006 SHALL have port rx_valid  input  1  rx_data holds a valid byte.
REQ-007 SHALL have port rx_ready  output  1  loader accepts a byte this cycle; a transfer occurs when rx_valid and rx_ready are both 1.
REQ-008 SHALL have port rom_we  output  1  single-cycle write strobe into the instruction ROM.
REQ-009 SHALL have port rom_addr  output  15  ROM word address, matching the CPU pc width.
REQ-010 SHALL have port rom_wdata  output  16  instruction word to write.
REQ-011 SHALL have port cpu_reset  output  1  drives the CPU reset input; 1 while loading.
REQ-012 SHALL have port cpu_hlt  output  1  drives the CPU hlt input; 1 while loading or in ERROR.
REQ-013 SHALL have port done  output  1  pulses for one cycle when a download completes successfully.
REQ-014 SHALL have port error  output  1  level; 1 while in ERROR.

Function
REQ-015 SHALL implement states IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, ERROR.
REQ-016 SHALL, in IDLE, hold rx_ready=0, cpu_reset=0, cpu_hlt=0, and move to LEN_HI on load_req=1.
REQ-017 SHALL assert rx_ready=1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK only.
REQ-018 SHALL capture word count N big-endian: LEN_HI byte -> N[15:8], LEN_LO byte -> N[7:0].
REQ-019 SHALL, after LEN_LO, go to ERROR if N > MAX_WORDS, to CHECK (or IDLE with done pulse when checksum is compiled out) if N == 0, else to DATA_HI with the address counter at 0.
REQ-020 SHALL assemble each word high byte first (DATA_HI -> rom_wdata[15:8], DATA_LO -> rom_wdata[7:0]).
REQ-021 SHALL enter WRITE for exactly one cycle after each DATA_LO byte, asserting rom_we=1 with the current rom_addr and rom_wdata; rx_ready=0 in WRITE.
REQ-022 SHALL increment rom_addr after each WRITE; after the Nth write go to CHECK (or IDLE), else DATA_HI.
REQ-023 SHALL keep rom_addr within 15 bits; N == 32768 ends at address 0x7FFF, with no wrap write.
REQ-024 SHALL hold cpu_reset=1 and cpu_hlt=1 from entering LEN_HI until returning to IDLE, so the CPU restarts from pc 0 on the cycle after done.
REQ-025 SHALL stall without state change while rx_valid=0; no timeout.
REQ-026 SHALL ignore load_req outside IDLE.
REQ-027 SHALL, in ERROR, hold error=1, cpu_hlt=1, cpu_reset=1, rx_ready=0, and leave only on load_req=1 (to LEN_HI, error cleared).

Reset
REQ-028 SHALL, on reset_n=0, immediately enter IDLE and clear rom_we, rom_addr, rom_wdata, N, checksum, done, error, rx_ready, cpu_reset, cpu_hlt to 0.
REQ-029 SHALL abort a download in progress on reset; partially written ROM contents are not restored.

Configuration
REQ-030 SHALL support macro HACK_LOADER_CHECKSUM_EN: when defined, a running XOR of every data byte is kept and the CHECK state accepts one byte; match -> IDLE with done, mismatch -> ERROR.
REQ-031 SHALL, without HACK_LOADER_CHECKSUM_EN, omit the CHECK state and checksum register; the final WRITE goes directly to IDLE with done.

Structure
REQ-032 SHALL place the state encoding typedef, HACK_ADDR_W=15 and HACK_WORD_W=16 in shared package hack_pkg.
REQ-033 SHALL use one sub-module, hack_byte_assembler (two bytes -> 16-bit word, valid pulse); all else inline.

Verification
REQ-034 SHALL verify: load_req, bytes 00 02 12 34 AB CD (+ checksum 0x40 if enabled) -> writes 0x1234@0, 0xABCD@1, done pulse, cpu_reset/hlt drop.
REQ-035 SHALL verify: count 00 00 -> no rom_we, done after LEN_LO (or after checksum byte 0x00).
REQ-036 SHALL verify: MAX_WORDS=4, count 00 05 -> error=1, cpu_hlt=1; then load_req with valid stream -> recovery and done.
REQ-037 SHALL verify: checksum enabled, data 00 01 FF 00 then checksum 0x00 -> ERROR; 0xFF -> done.
REQ-038 SHALL verify: reset_n low after first data byte -> all outputs 0 asynchronously, IDLE, no rom_we.
REQ-039 SHALL verify: rx_valid gaps of random length between bytes -> identical writes and done timing relative to the last byte.
